ef_pwm_deadtime: RTL and testbench
==================================

// Module: ef_pwm_deadtime
// PURPOSE
//  Dual-channel dead-time generator and fault-trip stage downstream of the 32-bit PWM generator.
//  Consumes raw pwmA/pwmB and drives complementary high-side/low-side gate signals per channel.
//  Inserts programmable dead bands on each edge, swallows pulses shorter than the dead band,
//  and forces all gates inactive on a latched fault.
// PARAMETERS
//  DT_W      8   width of dead-time counters/inputs (max band = 2**DT_W-1 cycles)
// PORTS
//  clk           in   1     clock
//  rst_n         in   1     asynchronous active-low reset
//  en            in   1     block enable; 0 = all gates inactive, channels idle
//  pwmA          in   1     raw PWM channel A (registered upstream, synchronous to clk)
//  pwmB          in   1     raw PWM channel B
//  dtA_rise      in   DT_W  A: cycles both gates off before hs turns on
//  dtA_fall      in   DT_W  A: cycles both gates off before ls turns on
//  dtB_rise      in   DT_W  B: same as dtA_rise
//  dtB_fall      in   DT_W  B: same as dtA_fall
//  hs_inv        in   1     invert all high-side outputs (quasi-static)
//  ls_inv        in   1     invert all low-side outputs (quasi-static)
//  fault         in   1     synchronous active-high trip request
//  fault_clr     in   1     single-cycle pulse; clears latched fault
//  fault_flag    out  1     latched fault status
//  pwmA_hs       out  1     A high-side gate
//  pwmA_ls       out  1     A low-side gate
//  pwmB_hs       out  1     B high-side gate
//  pwmB_ls       out  1     B low-side gate
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
//  Reset: state OFF, counters 0, hs_q/ls_q 0, fault_flag 0; pins = hs_q^hs_inv, ls_q^ls_inv.
//  Per-channel FSM states: OFF, LS_ON, DT_TO_HS, HS_ON, DT_TO_LS. hs_q/ls_q are registered with state.
//  - LS_ON & pwm=1: dt_rise==0 -> HS_ON; else -> DT_TO_HS, cnt<=dt_rise-1. ls_q drops on the same edge.
//  - DT_TO_HS: both off; cnt==0 -> HS_ON (hs_q=1); else cnt--. pwm=0 before expiry -> LS_ON (pulse swallowed).
//  - HS_ON & pwm=0: mirror of the above using dt_fall -> DT_TO_LS or LS_ON.
//  - DT_TO_LS: mirror of DT_TO_HS; pwm=1 before expiry -> HS_ON.
//  - OFF (en=0 or fault_flag=1): both off. On exit, go to DT_TO_HS or DT_TO_LS according to the current pwm.
//    The full dead band is always applied after OFF; if that band is 0, go directly to HS_ON or LS_ON.
//  - Net timing: pwm edge sampled at edge k -> outgoing gate off after edge k.
//    Incoming gate on after edge k+dt; exactly dt cycles with both gates off. hs_q & ls_q never both 1.
//  - dt inputs are sampled only when loading cnt; changes mid-band do not affect the current band.
//  Fault: fault=1 at edge k -> fault_flag=1, all channels to OFF, all gates off after edge k.
//   Priority order: fault > en > pwm events.
//   fault_clr clears fault_flag only when fault=0 in the same cycle; otherwise it is ignored.
//   fault_flag is retained while en=0.
//  en=0: channels go to OFF at the next edge and cnt<=0.
//  Reset mid-band: immediate return to the reset state; no residual count.
// STRUCTURE
//  Shared package ef_pwm_dt_pkg: state localparams (OFF=0, LS_ON=1, DT_TO_HS=2, HS_ON=3, DT_TO_LS=4)
//   and the DT_W default.
//  Sub-module ef_pwm_dt_channel (FSM + counter + registered hs_q/ls_q) is instantiated twice.
//  Top level holds the fault latch, the en/fault gating, and the output inversion XORs.
// TESTING
//  1. dtA_rise=3, dtA_fall=2, pwmA square wave of period 20 (10 high) ->
//     hs high 7 cycles, gap 3, ls high 8, gap 2; never overlapping.
//  2. dtA_rise=5; pwmA pulse 3 cycles high from LS_ON -> hs never asserts; ls off 3 cycles, then back on.
//  3. dtB_rise=0, dtB_fall=0 -> pwmB_hs tracks pwmB delayed by 1 cycle and pwmB_ls = its complement.
//  4. fault pulse during HS_ON -> all gates off next edge, fault_flag=1.
//     fault_clr while fault=1 is ignored; fault_clr after fault drops clears the flag.
//     Re-entry applies a full dead band before any gate turns on.
//  5. hs_inv=1, ls_inv=1, hold in reset -> all four pins read 1.
//     Release with en=0 -> pins remain 1 (all gates inactive).
//  6. Change dtA_rise from 8 to 2 mid-band -> current band still 8 cycles; next band 2 cycles.

Source files
------------

// File: rtl/ef_pwm_dt_pkg.sv
// rtl/ef_pwm_dt_pkg.sv - shared state encoding and defaults for the PWM dead-time stage
package ef_pwm_dt_pkg;

  localparam int DT_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_LS_ON    = 3'd1,
    ST_DT_TO_HS = 3'd2,
    ST_HS_ON    = 3'd3,
    ST_DT_TO_LS = 3'd4
  } dt_state_e;

endpackage

// File: rtl/ef_pwm_dt_channel.sv
// rtl/ef_pwm_dt_channel.sv - one complementary channel: FSM, dead-band counter, registered gates
module ef_pwm_dt_channel
  import ef_pwm_dt_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            pwm,
  input  logic [DT_W-1:0] dt_rise,
  input  logic [DT_W-1:0] dt_fall,
  output logic            hs_q,
  output logic            ls_q
);

  dt_state_e       state_q, state_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic            hs_d, ls_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!run) begin
      state_d = ST_OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        // OFF and the settled states share the band-load path: the full band is always applied
        ST_OFF, ST_LS_ON, ST_HS_ON: begin
          if (pwm && state_q != ST_HS_ON) begin
            if (dt_rise == '0) state_d = ST_HS_ON;
            else begin
              state_d = ST_DT_TO_HS;
              cnt_d   = dt_rise - 1'b1;
            end
          end else if (!pwm && state_q != ST_LS_ON) begin
            if (dt_fall == '0) state_d = ST_LS_ON;
            else begin
              state_d = ST_DT_TO_LS;
              cnt_d   = dt_fall - 1'b1;
            end
          end
        end
        ST_DT_TO_HS: begin
          if (!pwm) begin
            state_d = ST_LS_ON;
            cnt_d   = '0;
          end else if (cnt_q == '0) state_d = ST_HS_ON;
          else cnt_d = cnt_q - 1'b1;
        end
        ST_DT_TO_LS: begin
          if (pwm) begin
            state_d = ST_HS_ON;
            cnt_d   = '0;
          end else if (cnt_q == '0) state_d = ST_LS_ON;
          else cnt_d = cnt_q - 1'b1;
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end
      endcase
    end
    hs_d = (state_d == ST_HS_ON);
    ls_d = (state_d == ST_LS_ON);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      hs_q    <= 1'b0;
      ls_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hs_q    <= hs_d;
      ls_q    <= ls_d;
    end
  end

endmodule

// File: rtl/ef_pwm_deadtime.sv
// rtl/ef_pwm_deadtime.sv - dual-channel dead-time generator with latched fault trip and output polarity
module ef_pwm_deadtime
  import ef_pwm_dt_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            pwmA,
  input  logic            pwmB,
  input  logic [DT_W-1:0] dtA_rise,
  input  logic [DT_W-1:0] dtA_fall,
  input  logic [DT_W-1:0] dtB_rise,
  input  logic [DT_W-1:0] dtB_fall,
  input  logic            hs_inv,
  input  logic            ls_inv,
  input  logic            fault,
  input  logic            fault_clr,
  output logic            fault_flag,
  output logic            pwmA_hs,
  output logic            pwmA_ls,
  output logic            pwmB_hs,
  output logic            pwmB_ls
);

  logic fault_flag_q, fault_flag_d;
  logic run;
  logic a_hs_q, a_ls_q, b_hs_q, b_ls_q;

  always_comb begin
    fault_flag_d = fault_flag_q;
    if (fault) fault_flag_d = 1'b1;
    else if (fault_clr) fault_flag_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_flag_q <= 1'b0;
    else fault_flag_q <= fault_flag_d;
  end

  // Raw fault is included so gates drop on the same edge that latches the trip
  assign run = en & ~fault & ~fault_flag_q;

  ef_pwm_dt_channel #(.DT_W(DT_W)) u_ch_a (
    .clk(clk), .rst_n(rst_n), .run(run), .pwm(pwmA),
    .dt_rise(dtA_rise), .dt_fall(dtA_fall), .hs_q(a_hs_q), .ls_q(a_ls_q)
  );

  ef_pwm_dt_channel #(.DT_W(DT_W)) u_ch_b (
    .clk(clk), .rst_n(rst_n), .run(run), .pwm(pwmB),
    .dt_rise(dtB_rise), .dt_fall(dtB_fall), .hs_q(b_hs_q), .ls_q(b_ls_q)
  );

  assign fault_flag = fault_flag_q;
  assign pwmA_hs    = a_hs_q ^ hs_inv;
  assign pwmA_ls    = a_ls_q ^ ls_inv;
  assign pwmB_hs    = b_hs_q ^ hs_inv;
  assign pwmB_ls    = b_ls_q ^ ls_inv;

endmodule

// File: tb/tb_ef_pwm_deadtime.sv
// tb/tb_ef_pwm_deadtime.sv - directed self-checking bench for ef_pwm_deadtime
module tb_ef_pwm_deadtime;

  logic       clk = 1'b0;
  logic       rst_n, en, pwmA, pwmB, hs_inv, ls_inv, fault, fault_clr;
  logic [7:0] dtA_rise, dtA_fall, dtB_rise, dtB_fall;
  logic       fault_flag, pwmA_hs, pwmA_ls, pwmB_hs, pwmB_ls;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ef_pwm_deadtime #(.DT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pwmA(pwmA), .pwmB(pwmB),
    .dtA_rise(dtA_rise), .dtA_fall(dtA_fall), .dtB_rise(dtB_rise), .dtB_fall(dtB_fall),
    .hs_inv(hs_inv), .ls_inv(ls_inv), .fault(fault), .fault_clr(fault_clr),
    .fault_flag(fault_flag), .pwmA_hs(pwmA_hs), .pwmA_ls(pwmA_ls),
    .pwmB_hs(pwmB_hs), .pwmB_ls(pwmB_ls)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [9:0] patb;

  initial begin
    rst_n = 1'b0; en = 1'b0; pwmA = 1'b0; pwmB = 1'b0; hs_inv = 1'b0; ls_inv = 1'b0;
    fault = 1'b0; fault_clr = 1'b0;
    dtA_rise = 8'd3; dtA_fall = 8'd2; dtB_rise = 8'd0; dtB_fall = 8'd0;
    #12;
    chk("rst_pins", {28'd0, pwmA_hs, pwmA_ls, pwmB_hs, pwmB_ls}, 32'h0);
    chk("rst_flag", {31'd0, fault_flag}, 32'd0);
    tick(1);
    rst_n = 1'b1;
    en    = 1'b1;
    tick(5);
    chk("init_a_ls", {31'd0, pwmA_ls}, 32'd1);
    chk("init_b_ls", {31'd0, pwmB_ls}, 32'd1);

    // square wave period 20, 10 high: hs 7 cycles, ls 8 cycles
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 20; i++) begin
        pwmA = (i < 10);
        tick(1);
        chk("t1_hs", {31'd0, pwmA_hs}, {31'd0, (i >= 3 && i < 10)});
        chk("t1_ls", {31'd0, pwmA_ls}, {31'd0, (i >= 12)});
        chk("t1_ovl", {31'd0, pwmA_hs & pwmA_ls}, 32'd0);
      end
    end

    // short pulse swallowed
    dtA_rise = 8'd5;
    for (int i = 0; i < 8; i++) begin
      pwmA = (i < 3);
      tick(1);
      chk("t2_hs", {31'd0, pwmA_hs}, 32'd0);
      chk("t2_ls", {31'd0, pwmA_ls}, {31'd0, (i >= 3)});
    end

    // zero dead time on B
    patb = 10'b1001101101;
    for (int i = 0; i < 10; i++) begin
      pwmB = patb[i];
      tick(1);
      chk("t3_hs", {31'd0, pwmB_hs}, {31'd0, patb[i]});
      chk("t3_ls", {31'd0, pwmB_ls}, {31'd0, ~patb[i]});
    end

    // fault trip and recovery
    dtA_rise = 8'd3;
    pwmA = 1'b1;
    pwmB = 1'b0;
    tick(5);
    chk("t4_pre_hs", {31'd0, pwmA_hs}, 32'd1);
    fault = 1'b1;
    tick(1);
    chk("t4_trip_pins", {28'd0, pwmA_hs, pwmA_ls, pwmB_hs, pwmB_ls}, 32'h0);
    chk("t4_trip_flag", {31'd0, fault_flag}, 32'd1);
    fault_clr = 1'b1;
    tick(1);
    chk("t4_clr_ignored", {31'd0, fault_flag}, 32'd1);
    fault = 1'b0;
    fault_clr = 1'b0;
    en = 1'b0;
    tick(2);
    chk("t4_flag_hold_en0", {31'd0, fault_flag}, 32'd1);
    en = 1'b1;
    tick(1);
    chk("t4_latched_pins", {28'd0, pwmA_hs, pwmA_ls, pwmB_hs, pwmB_ls}, 32'h0);
    fault_clr = 1'b1;
    tick(1);
    chk("t4_clr_flag", {31'd0, fault_flag}, 32'd0);
    fault_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("t4_reentry_hs", {31'd0, pwmA_hs}, {31'd0, (i == 3)});
      chk("t4_reentry_als", {31'd0, pwmA_ls}, 32'd0);
      chk("t4_reentry_bls", {31'd0, pwmB_ls}, 32'd1);
    end

    // dt change mid-band takes effect on the next band only
    pwmA = 1'b0;
    tick(4);
    dtA_rise = 8'd8;
    for (int i = 0; i < 10; i++) begin
      if (i == 1) dtA_rise = 8'd2;
      pwmA = 1'b1;
      tick(1);
      chk("t6_band8_hs", {31'd0, pwmA_hs}, {31'd0, (i >= 8)});
      chk("t6_band8_ls", {31'd0, pwmA_ls}, 32'd0);
    end
    pwmA = 1'b0;
    tick(4);
    for (int i = 0; i < 4; i++) begin
      pwmA = 1'b1;
      tick(1);
      chk("t6_band2_hs", {31'd0, pwmA_hs}, {31'd0, (i >= 2)});
    end

    // inverted outputs, reset mid-band, en=0 keeps gates inactive
    pwmA = 1'b0;
    tick(4);
    dtA_rise = 8'd8;
    pwmA = 1'b1;
    tick(3);
    hs_inv = 1'b1;
    ls_inv = 1'b1;
    rst_n  = 1'b0;
    #1;
    chk("t5_rst_pins", {28'd0, pwmA_hs, pwmA_ls, pwmB_hs, pwmB_ls}, 32'hF);
    en = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("t5_en0_pins", {28'd0, pwmA_hs, pwmA_ls, pwmB_hs, pwmB_ls}, 32'hF);
    chk("t5_en0_flag", {31'd0, fault_flag}, 32'd0);
    en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick(1);
      chk("t5_full_band_hs", {31'd0, pwmA_hs}, {31'd0, (i < 8)});
      chk("t5_full_band_ls", {31'd0, pwmA_ls}, 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
